// File: rtl/pmc_shift_seq_pkg.sv
// rtl/pmc_shift_seq_pkg.sv - shared types and constants for the pixel matrix shift sequencer
// Purpose: lane/word geometry, packed lane data type and sequencer state encoding.
// Ports: none (package).
package pmc_shift_seq_pkg;

   localparam int PMC_LANES        = 16;
   localparam int PMC_SEQ_MAX_BITS = 32;
   localparam int PMC_WORD_W       = PMC_SEQ_MAX_BITS;
   localparam int PMC_DIV_W        = 8;

   // Lane k occupies bits [k*PMC_WORD_W +: PMC_WORD_W].
   typedef logic [PMC_LANES*PMC_WORD_W-1:0] pmc_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } pmc_seq_state_t;

endpackage

// File: rtl/pmc_shift_seq_if.sv
// rtl/pmc_shift_seq_if.sv - control/data bundle between PMC register file, sequencer and matrix pads
// Purpose: groups the start/config inputs, lane data and matrix pad signals.
// Ports: master = PMC side driving requests and return bits, slave = sequencer.
interface pmc_shift_seq_if
   import pmc_shift_seq_pkg::*;
#(
   parameter int LANES  = PMC_LANES,
   parameter int WORD_W = PMC_WORD_W,
   parameter int DIV_W  = PMC_DIV_W
) ();

   logic                      start_i;
   logic                      abort_i;
   logic [5:0]                bit_cnt_i;
   logic [DIV_W-1:0]          half_i;
   logic                      chain_sel_i;
   logic                      store_req_i;
   logic [LANES*WORD_W-1:0]   dout_i;
   logic [LANES-1:0]          sh_in_i;

   logic [LANES-1:0]          sh_out_o;
   logic                      clk_sh_o;
   logic                      sh_a_o;
   logic                      sh_b_o;
   logic                      store_o;
   logic                      busy_o;
   logic                      done_o;
   logic [LANES*WORD_W-1:0]   din_o;

   modport master (
      output start_i, abort_i, bit_cnt_i, half_i, chain_sel_i, store_req_i, dout_i, sh_in_i,
      input  sh_out_o, clk_sh_o, sh_a_o, sh_b_o, store_o, busy_o, done_o, din_o
   );

   modport slave (
      input  start_i, abort_i, bit_cnt_i, half_i, chain_sel_i, store_req_i, dout_i, sh_in_i,
      output sh_out_o, clk_sh_o, sh_a_o, sh_b_o, store_o, busy_o, done_o, din_o
   );

endinterface

// File: rtl/pmc_seq_timer.sv
// rtl/pmc_seq_timer.sv - phase down-counter for the shift clock half period
// Purpose: loads a value and counts down to zero, then holds at zero.
// Ports: clk, rst (async active-high), load, value -> expire (count == 0).
module pmc_seq_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] value,
   output logic             expire
);

   logic [DIV_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/pmc_shift_seq.sv
// rtl/pmc_shift_seq.sv - serial shift sequencer for the pixel matrix config/readout chains
// Purpose: latches per-lane words on start, shifts N bits MSB first with a
//          programmable clk_sh half period and captures the return bits.
// Ports: clk, rst (async active-high), bus (slave modport: start/abort/config,
//        dout/din lane words, sh_in/sh_out, clk_sh, sh_a/sh_b, busy/done/store).
module pmc_shift_seq
   import pmc_shift_seq_pkg::*;
#(
   parameter int LANES  = PMC_LANES,
   parameter int WORD_W = PMC_WORD_W,
   parameter int DIV_W  = PMC_DIV_W
) (
   input  logic            clk,
   input  logic            rst,
   pmc_shift_seq_if.slave  bus
);

   pmc_seq_state_t    state, state_nxt;
   logic [5:0]        remain;
   logic [DIV_W-1:0]  half_lat;
   logic              sel_lat;
   logic              store_lat;
   logic [WORD_W-1:0] sh_reg  [LANES];
   logic [WORD_W-1:0] din_reg [LANES];

   logic [5:0]        neff_in;
   logic              accept;
   logic              timer_load;
   logic [DIV_W-1:0]  timer_value;
   logic              timer_expire;

   logic              busy;
   logic              clk_sh;
   logic              done;

   assign neff_in = (bus.bit_cnt_i > 6'(WORD_W)) ? 6'(WORD_W) : bus.bit_cnt_i;
   assign accept  = (state == IDLE) && bus.start_i && !bus.abort_i;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = (neff_in == '0) ? DONE : LOW;
         LOW:  if (timer_expire) state_nxt = HIGH;
         HIGH: if (timer_expire) state_nxt = (remain == 6'd1) ? DONE : LOW;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.abort_i) state_nxt = IDLE;
   end

   // Outputs decode only registered state, so nothing flows from inputs to outputs
   always_comb begin
      busy   = 1'b0;
      clk_sh = 1'b0;
      done   = 1'b0;
      unique case (state)
         LOW:  busy = 1'b1;
         HIGH: begin
            busy   = 1'b1;
            clk_sh = 1'b1;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Reload on every entry into a LOW or HIGH phase; H comes straight from the
   // input on the start cycle because half_lat is only written on that same edge.
   assign timer_load  = (state_nxt != state) && ((state_nxt == LOW) || (state_nxt == HIGH));
   assign timer_value = (state == IDLE) ? bus.half_i : half_lat;

   pmc_seq_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .value  (timer_value),
      .expire (timer_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remain    <= '0;
         half_lat  <= '0;
         sel_lat   <= 1'b0;
         store_lat <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            sh_reg[k]  <= '0;
            din_reg[k] <= '0;
         end
      end else if (accept) begin
         remain    <= neff_in;
         half_lat  <= bus.half_i;
         sel_lat   <= bus.chain_sel_i;
         store_lat <= bus.store_req_i;
         // Left-align the Neff-bit field so bit Neff-1 sits at the MSB
         for (int k = 0; k < LANES; k++) begin
            sh_reg[k]  <= bus.dout_i[k*WORD_W +: WORD_W] << (6'(WORD_W) - neff_in);
            din_reg[k] <= '0;
         end
      end else if (!bus.abort_i) begin
         if ((state == LOW) && timer_expire) begin
            for (int k = 0; k < LANES; k++) begin
               din_reg[k] <= {din_reg[k][WORD_W-2:0], bus.sh_in_i[k]};
            end
         end
         if ((state == HIGH) && timer_expire) begin
            remain <= remain - 6'd1;
            if (remain != 6'd1) begin
               for (int k = 0; k < LANES; k++) begin
                  sh_reg[k] <= {sh_reg[k][WORD_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign bus.clk_sh_o = clk_sh;
   assign bus.busy_o   = busy;
   assign bus.done_o   = done;
   assign bus.store_o  = done & store_lat;
   assign bus.sh_a_o   = busy & ~sel_lat;
   assign bus.sh_b_o   = busy & sel_lat;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign bus.sh_out_o[k]                = busy & sh_reg[k][WORD_W-1];
      assign bus.din_o[k*WORD_W +: WORD_W] = din_reg[k];
   end

endmodule

// File: tb/tb_pmc_shift_seq.sv
// tb/tb_pmc_shift_seq.sv - self-checking bench for pmc_shift_seq
module tb_pmc_shift_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        loop_en;
   logic [15:0] sh_in_drv;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pmc_shift_seq_if bus ();

   assign bus.sh_in_i = loop_en ? bus.sh_out_o : sh_in_drv;

   pmc_shift_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          n;
      int          h;
      bit          sel;
      bit          st;
      bit          loop;
      int          lane;
      logic [31:0] word;
      int          abort_high;
      int          restart_at;
      int          exp_busy;
      int          exp_pulses;
      int          exp_done;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_seq(input vec_t v, output int busy_cnt, output int pulses, output int done_cnt);
      logic [511:0] dw;
      logic [31:0]  acc [16];
      logic [63:0]  m;
      logic [63:0]  e [16];
      int neff, cap, done_at, abort_cyc, total, j, bad, kk;
      bit store_seen, stray_store, shout_ok, ab_ok, idle_ok, abort_ok, prev_clk, eb;
      for (int k = 0; k < 16; k++) begin
         dw[k*32 +: 32] = $urandom;
         acc[k] = '0;
      end
      if (v.lane >= 0) dw[v.lane*32 +: 32] = v.word;
      neff = (v.n > 32) ? 32 : v.n;
      cap  = (v.abort_high > 0) ? v.abort_high : neff;
      total = neff * (2 * v.h + 2) + 6;
      busy_cnt = 0; pulses = 0; done_cnt = 0; done_at = 0; abort_cyc = 0;
      store_seen = 0; stray_store = 0; shout_ok = 1; ab_ok = 1; idle_ok = 1; abort_ok = 1; prev_clk = 0;

      bus.bit_cnt_i   = 6'(v.n);
      bus.half_i      = 8'(v.h);
      bus.chain_sel_i = v.sel;
      bus.store_req_i = v.st;
      bus.dout_i      = dw;
      loop_en         = v.loop;
      sh_in_drv       = 16'($urandom);
      bus.start_i     = 1'b1;
      @(negedge clk);
      // Scramble config after the start edge: the sequencer must use latched copies
      bus.dout_i      = {16{$urandom}};
      bus.half_i      = 8'($urandom);
      bus.bit_cnt_i   = 6'($urandom);
      bus.chain_sel_i = ~v.sel;
      bus.store_req_i = ~v.st;
      for (int cyc = 1; cyc <= total; cyc++) begin
         bus.start_i = (cyc == v.restart_at);
         bus.abort_i = 1'b0;
         if (bus.busy_o) busy_cnt++;
         if (bus.sh_a_o !== (bus.busy_o & ~v.sel) || bus.sh_b_o !== (bus.busy_o & v.sel)) ab_ok = 0;
         if (!bus.busy_o && (bus.clk_sh_o || bus.sh_out_o != '0)) idle_ok = 0;
         if (abort_cyc > 0 && cyc == abort_cyc + 1 && (bus.busy_o || bus.clk_sh_o || bus.done_o)) abort_ok = 0;
         if (bus.done_o) begin
            done_cnt++;
            done_at = cyc;
            store_seen = bus.store_o;
         end else if (bus.store_o) begin
            stray_store = 1;
         end
         if (bus.clk_sh_o && !prev_clk) begin
            j = pulses;
            pulses++;
            for (int k = 0; k < 16; k++) begin
               if (j < neff) begin
                  eb = dw[k*32 + neff - 1 - j];
                  if (bus.sh_out_o[k] !== eb) shout_ok = 0;
                  acc[k] = {acc[k][30:0], v.loop ? eb : sh_in_drv[k]};
               end else begin
                  shout_ok = 0;
               end
            end
            if (!v.loop) sh_in_drv = 16'($urandom);
            if (pulses == v.abort_high) begin
               bus.abort_i = 1'b1;
               abort_cyc = cyc;
            end
         end
         prev_clk = bus.clk_sh_o;
         @(negedge clk);
      end
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;

      chk("store", longint'(store_seen | stray_store), longint'(v.st && v.exp_done != 0));
      if (v.exp_done != 0) chk("done_at", longint'(done_at), longint'(neff * (2 * v.h + 2) + 1));
      chk("sh_out_seq", longint'(shout_ok), 1);
      chk("chain_en", longint'(ab_ok), 1);
      chk("idle_outputs", longint'(idle_ok), 1);
      if (v.abort_high > 0) begin
         chk("abort_seen", longint'(abort_cyc > 0), 1);
         chk("abort_idle", longint'(abort_ok), 1);
      end
      m = (64'd1 << neff) - 64'd1;
      bad = -1;
      for (int k = 0; k < 16; k++) begin
         if (v.loop) e[k] = ({32'd0, dw[k*32 +: 32]} & m) >> (neff - cap);
         else        e[k] = {32'd0, acc[k]};
         if (bus.din_o[k*32 +: 32] !== e[k][31:0] && bad < 0) bad = k;
      end
      kk = (bad < 0) ? 0 : bad;
      chk($sformatf("din_lane%0d", kk), longint'(bus.din_o[kk*32 +: 32]), longint'(e[kk][31:0]));
   endtask

   initial begin
      int b, p, d, cnt, nf, hh, ab;
      bit seen;
      vec_t v;

      //           n   h  sel   st    loop  lane word          abrt rst busy pul done
      tbl[0] = '{  1,  0, 1'b0, 1'b1, 1'b1, 0,   32'h0000_0001, 0,   0,  2,   1,  1};
      tbl[1] = '{ 32,  3, 1'b0, 1'b0, 1'b1, 5,   32'hA5A5_0F0F, 0,   0,  256, 32, 1};
      tbl[2] = '{  8,  1, 1'b1, 1'b1, 1'b1, 0,   32'hFFFF_FF3C, 0,   0,  32,  8,  1};
      tbl[3] = '{  0,  5, 1'b0, 1'b1, 1'b1, -1,  32'h0,         0,   0,  0,   0,  1};
      tbl[4] = '{ 40,  0, 1'b1, 1'b0, 1'b1, -1,  32'h0,         0,   0,  64,  32, 1};
      tbl[5] = '{ 16,  2, 1'b0, 1'b1, 1'b1, -1,  32'h0,         5,   0,  28,  5,  0};
      tbl[6] = '{ 16,  2, 1'b0, 1'b1, 1'b1, -1,  32'h0,         0,   0,  96,  16, 1};
      tbl[7] = '{ 12,  1, 1'b1, 1'b1, 1'b1, -1,  32'h0,         0,   5,  48,  12, 1};
      tbl[8] = '{ 20,  2, 1'b0, 1'b1, 1'b0, -1,  32'h0,         0,   0,  120, 20, 1};
      tbl[9] = '{  4,  0, 1'b1, 1'b1, 1'b1, -1,  32'h0,         0,   9,  8,   4,  1};

      rst = 1'b1;
      bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.bit_cnt_i = '0; bus.half_i = '0;
      bus.chain_sel_i = 1'b0; bus.store_req_i = 1'b0; bus.dout_i = '0;
      loop_en = 1'b0; sh_in_drv = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",   longint'(bus.busy_o), 0);
      chk("rst_clk_sh", longint'(bus.clk_sh_o), 0);
      chk("rst_done",   longint'(bus.done_o | bus.store_o), 0);
      chk("rst_chain",  longint'({bus.sh_a_o, bus.sh_b_o}), 0);
      chk("rst_sh_out", longint'(bus.sh_out_o), 0);
      chk("rst_din",    longint'(bus.din_o != '0), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_seq(tbl[i], b, p, d);
         chk($sformatf("v%0d_busy_cycles", i), longint'(b), longint'(tbl[i].exp_busy));
         chk($sformatf("v%0d_clk_sh_pulses", i), longint'(p), longint'(tbl[i].exp_pulses));
         chk($sformatf("v%0d_done_count", i), longint'(d), longint'(tbl[i].exp_done));
      end

      // Reset asserted in the middle of a HIGH phase
      bus.bit_cnt_i = 6'd16; bus.half_i = 8'd2; bus.chain_sel_i = 1'b1; bus.store_req_i = 1'b1;
      bus.dout_i = {16{32'hFFFF_FFFF}}; loop_en = 1'b1; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (bus.clk_sh_o) seen = 1;
      end
      chk("rst_test_reached_high", longint'(seen), 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy",   longint'(bus.busy_o), 0);
      chk("mid_rst_clk_sh", longint'(bus.clk_sh_o), 0);
      chk("mid_rst_chain",  longint'({bus.sh_a_o, bus.sh_b_o}), 0);
      chk("mid_rst_sh_out", longint'(bus.sh_out_o), 0);
      chk("mid_rst_din",    longint'(bus.din_o != '0), 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.done_o || bus.store_o || bus.busy_o) cnt++;
      end
      chk("mid_rst_no_done", longint'(cnt), 0);

      // Randomized sequences against the arithmetic reference
      for (int i = 0; i < 12; i++) begin
         v.n = int'($urandom_range(0, 40));
         v.h = int'($urandom_range(0, 3));
         v.sel = 1'($urandom); v.st = 1'($urandom); v.loop = 1'($urandom);
         v.lane = -1; v.word = '0; v.restart_at = 0; v.abort_high = 0;
         nf = (v.n > 32) ? 32 : v.n;
         hh = 2 * v.h + 2;
         ab = 0;
         if (nf > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, nf));
         v.abort_high = ab;
         if (ab == 0 && $urandom_range(0, 1) == 1) v.restart_at = int'($urandom_range(1, nf * hh + 1));
         if (ab > 0) begin
            v.exp_busy = (ab - 1) * hh + (v.h + 1) + 1;
            v.exp_pulses = ab;
            v.exp_done = 0;
         end else begin
            v.exp_busy = nf * hh;
            v.exp_pulses = nf;
            v.exp_done = 1;
         end
         run_seq(v, b, p, d);
         chk($sformatf("r%0d_busy_cycles", i), longint'(b), longint'(v.exp_busy));
         chk($sformatf("r%0d_clk_sh_pulses", i), longint'(p), longint'(v.exp_pulses));
         chk($sformatf("r%0d_done_count", i), longint'(d), longint'(v.exp_done));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmc_shift_seq.md
Name: pmc_shift_seq

Overview:
- Hardware sequencer for the pixel matrix serial configuration/readout chains. It replaces bit-banging of clk_sh/sh_a/sh_b by the coprocessor.
- On start, latches 16 lanes x 32-bit dout words. It shifts N bits per lane out serially, MSB first, with a programmable shift-clock half period.
- It captures the matrix return bits into 16 din words.
- It sits between the PMC register file (dout/din, ctrl) and the matrix pads. The PMC muxes its outputs onto the ctrl lines when the sequencer is busy.

Parameters:
- LANES, 16, number of parallel serial lanes.
- WORD_W, 32, bits per lane word; also the maximum shift length.
- DIV_W, 8, width of half-period setting.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start_i  input  1  one-cycle start request; honoured only in IDLE.
- abort_i  input  1  stop immediately; has priority over all other events.
- bit_cnt_i  input  6  number of bits to shift (N).
- half_i  input  DIV_W  half period H; each clk_sh phase lasts H+1 clk cycles.
- chain_sel_i  input  1  0 selects chain A, 1 selects chain B.
- store_req_i  input  1  pulse store_o on normal completion.
- dout_i  input  LANES*WORD_W  packed pmc_data_t; lane k occupies bits [k*32 +: 32].
- sh_in_i  input  LANES  serial return bits from the matrix.
- sh_out_o  output  LANES  serial data to the matrix.
- clk_sh_o  output  1  shift clock.
- sh_a_o  output  1  chain A enable.
- sh_b_o  output  1  chain B enable.
- store_o  output  1  store pulse.
- busy_o  output  1  sequence in progress.
- done_o  output  1  one-cycle completion pulse.
- din_o  output  LANES*WORD_W  captured words.

Behaviour:
- Reset: every output is 0, state is IDLE, all internal registers are cleared. Reset mid-sequence aborts with no done_o.
- States: IDLE, LOW, HIGH, DONE.
- Decided interface: one clock; reset is asynchronous and active-high.
- Start latching, on start_i in IDLE:
  - Neff = min(bit_cnt_i, 32).
  - H is latched from half_i; chain_sel_i and store_req_i are latched.
  - Each lane's shift register is loaded with dout_i lane << (32-Neff), so bit Neff-1 is presented first.
  - The din capture registers are cleared.
- Neff = 0: go directly to DONE. No clk_sh_o edges, din_o = 0.
- Neff > 0: go to LOW.
- Phase timer: reloads H on each phase entry and decrements to 0. The phase ends in the cycle where the timer is 0.
- LOW: clk_sh_o=0; sh_out_o = MSB of each lane shift register. At phase end, go to HIGH.
- LOW->HIGH edge: sample sh_in_i into each din register at the LSB (shift left by 1).
- HIGH: clk_sh_o=1. At phase end, decrement the remaining count.
  - If the count reaches 0, go to DONE.
  - Otherwise shift the dout registers left by 1 and go to LOW.
- DONE: busy_o=0, done_o=1 for 1 cycle, store_o = latched store_req for the same cycle. Then go to IDLE.
- busy_o: 1 in LOW/HIGH only. It is high for exactly Neff*(2H+2) cycles, starting the cycle after start_i.
- sh_a_o = busy_o & ~sel; sh_b_o = busy_o & sel.
- din_o: captured bits are right-aligned (first bit ends at bit Neff-1); upper bits are 0. din_o holds its value until the next start.
- abort_i in LOW/HIGH/DONE: next cycle IDLE, clk_sh_o=0, busy_o=0, no done_o/store_o. din_o holds the partial capture.
- start_i while not IDLE: ignored, including in the DONE cycle.
- start_i and abort_i together in IDLE: abort wins and start is ignored.
- sh_out_o: 0 in IDLE/DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- pmc_pkg additions:
  - pmc_seq_state_t enum {IDLE, LOW, HIGH, DONE}.
  - Constant PMC_SEQ_MAX_BITS = 32.
  - Reuse pmc_data_t for dout_i/din_o.
- Sub-module pmc_seq_timer (DIV_W down-counter).
  - Inputs: load, value.
  - Output: expire, asserted when count==0.
  - Reused for the phase timer.

Test Plan:
- N=1, H=0, lane0 dout=0x1, sh_in_i[0]=1 -> busy for 2 cycles, one clk_sh pulse (1 cycle low, 1 high), sh_out_o[0]=1, din lane0=0x1, done one cycle later.
- N=32, H=3, dout lane5=0xA5A5_0F0F, sh_in looped back to sh_out -> 32 clk_sh periods of 8 cycles each, busy=256 cycles, din lane5=0xA5A5_0F0F; other lanes match their dout.
- N=8, H=1, dout lane0=0xFFFF_FF3C, loopback, chain_sel=1 -> sh_out sequence 0,0,1,1,1,1,0,0, din lane0=0x0000_003C, sh_b_o high and sh_a_o low throughout busy.
- N=0 and N=40 -> N=0: done the cycle after start, no clk_sh edge, din=0. N=40: exactly 32 clk_sh pulses.
- abort_i on the 5th HIGH phase (N=16, H=2) -> next cycle IDLE, clk_sh=0, no done/store, din lane holds 5 captured bits; restart then completes normally.
- start_i during busy, and rst asserted mid-HIGH -> start ignored with busy length unchanged; on reset all outputs are 0 immediately and there is no done.
